// File: rtl/race_seq_pkg.sv
// Shared types and default parameter constants for the race-counter conversion sequencer.
package race_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RACE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam int DEF_NBITS         = 8;
    localparam int DEF_RST_CYCLES    = 4;
    localparam int DEF_WINDOW_CYCLES = 1024;

endpackage

// File: rtl/race_sync.sv
// Two-flop synchronizer for the asynchronous race winner bit.
module race_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/race_sequencer.sv
// Sequences NBITS clear/race/sample measurements into one conversion word.
// Optional RACE_SEQ_POPCOUNT_EN adds a registered ones_count output.
module race_sequencer
    import race_seq_pkg::*;
#(
    parameter int NBITS         = DEF_NBITS,
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             race_val,
    output logic             race_rst_n,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [NBITS-1:0] result
`ifdef RACE_SEQ_POPCOUNT_EN
    ,
    output logic [$clog2(NBITS+1)-1:0] ones_count
`endif
);

    if (NBITS < 1 || RST_CYCLES < 1 || WINDOW_CYCLES < 3) begin : g_param_check
        $error("race_sequencer: need NBITS>=1, RST_CYCLES>=1, WINDOW_CYCLES>=3");
    end

    // One phase counter serves both CLEAR and RACE, so size it for the longer one.
    localparam int CNT_MAX = (WINDOW_CYCLES > RST_CYCLES) ? WINDOW_CYCLES : RST_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);
    localparam int BW      = $clog2(NBITS + 1);

    localparam logic [CW-1:0] CLR_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYCLES - 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(CNT_MAX - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
    localparam logic [BW-1:0] BIT_TOP  = BW'(NBITS);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [NBITS-1:0]  result_q, result_d;
    logic              race_synced;

    race_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (race_val),
        .q   (race_synced)
    );

    assign busy         = (state_q == ST_CLEAR) || (state_q == ST_RACE) || (state_q == ST_SAMPLE);
    assign race_rst_n   = (state_q == ST_RACE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        result_d  = result_q;

        if (abort && busy) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
            result_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d   = ST_CLEAR;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        result_d  = '0;
                    end
                end
                ST_CLEAR: begin
                    if (cnt_q >= CLR_LAST) begin
                        state_d = ST_RACE;
                        cnt_d   = '0;
                    end else if (cnt_q < CNT_TOP) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RACE: begin
                    if (cnt_q >= WIN_LAST) begin
                        state_d = ST_SAMPLE;
                        cnt_d   = '0;
                    end else if (cnt_q < CNT_TOP) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    // Shift left so the first measurement lands in the MSB.
                    result_d = (result_q << 1) | NBITS'(race_synced);
                    if (bit_cnt_q < BIT_TOP)
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d = (bit_cnt_q >= BIT_LAST) ? ST_DONE : ST_CLEAR;
                end
                ST_DONE: begin
                    if (result_ready)
                        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            result_q  <= result_d;
        end
    end

`ifdef RACE_SEQ_POPCOUNT_EN
    localparam int OW = $clog2(NBITS + 1);

    logic [OW-1:0] ones_count_q, ones_count_d;

    always_comb begin
        ones_count_d = '0;
        for (int i = 0; i < NBITS; i++)
            ones_count_d = ones_count_d + OW'(result_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            ones_count_q <= '0;
        else
            ones_count_q <= ones_count_d;
    end

    assign ones_count = ones_count_q;
`endif

endmodule
